instr_issuer: RTL
=================

// Module: instr_issuer
// PURPOSE
//  Issuing end of the controller's start/waiting handshake. Buffers 16-bit instructions in a small FIFO.
//  Decodes each instruction into opcode/ALU_op/shift_op/register fields and pulses start to the controller.
//  Holds all decoded fields stable until the controller returns to waiting.
//  Sits between instruction source (switches/loader) and controller + datapath.
// PARAMETERS
//  DEPTH   4   FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      instruction offered
//  in_instr   in   16     instruction word
//  in_ready   out  1      FIFO can accept (count < DEPTH)
//  waiting    in   1      controller idle in wait state
//  start      out  1      one-cycle issue pulse to controller
//  opcode     out  3      IR[15:13]
//  ALU_op     out  2      IR[12:11]
//  shift_op   out  2      IR[4:3]
//  rn/rd/rm   out  3 ea   IR[10:8] / IR[7:5] / IR[2:0]
//  sximm8     out  16     sign-extended IR[7:0]
//  sximm5     out  16     sign-extended IR[4:0]
//  busy       out  1      instruction in flight (state != S_IDLE)
//  fifo_count out  $clog2(DEPTH+1)  occupied entries
//  illegal    out  1      one-cycle pulse: popped word had opcode not in {110,101}, dropped
// BEHAVIOUR
//  Reset: FIFO empty, IR=16'h0, start=0, busy=0, illegal=0, state S_IDLE. in_ready=1 while/after reset.
//  Push: in_valid & in_ready at edge -> write, count+1. Push+pop same edge -> count unchanged.
//   Full: in_ready=0, no push. No bypass: an empty FIFO does not issue in the push cycle.
//  FSM (states in pkg):
//   S_IDLE : if count>0 & waiting -> pop into IR.
//            legal opcode -> S_START; illegal -> illegal=1 next cycle, stay S_IDLE.
//   S_START: start=1 (registered, exactly one cycle) -> S_BUSY unconditionally.
//   S_BUSY : start=0; stay until waiting==1 sampled.
//            Then: if count>0 -> pop+load IR (legal -> S_START, illegal -> pulse, S_IDLE); else S_IDLE.
//            Back-to-back issue permitted. First S_BUSY cycle ignores waiting (controller deasserts it that cycle).
//  Latency: push at edge e0 -> pop/IR load at e1 -> start high cycle after e1 -> controller accepts at e2.
//  Field outputs are pure functions of IR. They change only on IR load, never while S_START/S_BUSY.
//  Pointers wrap mod DEPTH; count saturates impossible by construction.
//  Reset asserted mid-instruction: immediate return to reset values, FIFO contents discarded.
//  waiting=0 in S_IDLE: no pop, FIFO holds.
// CONFIGURATION
//  INSTR_ISSUER_RETIRE_CNT_EN defined:
//   adds output retired [15:0].
//   Increments (wraps at 16'hFFFF->0) on each S_BUSY->exit with waiting==1.
//   Illegal drops are not counted. Reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  cpu_pkg:
//   opcode consts OP_MOV=3'b110, OP_ALU=3'b101
//   ALU_op consts ADD/CMP/AND/MVN
//   field bit-position localparams
//   typedef enum logic[1:0] {S_IDLE,S_START,S_BUSY} issue_state_t
//  Sub-module instr_fifo #(DEPTH,16): push/pop/count, no bypass.
//  Top holds FSM, IR, decode.
// TESTING
//  - Reset, push 16'hD2A5 (MOV R2,#-91), waiting=1 -> start high one cycle; rn=2, sximm8=16'hFFA5, opcode=110.
//  - Push ADD 16'hA0E1 while waiting held 0 for 5 cycles -> no start. waiting=1 -> start next-but-one cycle.
//    rd=7, rm=1, ALU_op=00.
//  - Fill DEPTH=4 with waiting=0 -> in_ready=0, 5th push ignored, fifo_count=4.
//    Drain with a controller model -> 4 starts, in order, fields stable across each busy window.
//  - Push 16'h0000 (illegal) then 16'hB800 (MVN) -> illegal pulse once, no start for it.
//    Then start for MVN, ALU_op=11.
//  - Assert rst_n=0 during S_BUSY with 2 queued -> start=0, busy=0, fifo_count=0, IR fields 0 immediately.
//  - With INSTR_ISSUER_RETIRE_CNT_EN, run 3 legal + 1 illegal -> retired=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction issuer.
// Contents: opcode and ALU_op encodings, instruction-word field bit
// positions, the issue FSM state type, and small decode helpers
// (legal-opcode test, sign extension of immediates).
package cpu_pkg;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 13;
  localparam int ALU_HI   = 12;
  localparam int ALU_LO   = 11;
  localparam int RN_HI    = 10;
  localparam int RN_LO    = 8;
  localparam int RD_HI    = 7;
  localparam int RD_LO    = 5;
  localparam int SH_HI    = 4;
  localparam int SH_LO    = 3;
  localparam int RM_HI    = 2;
  localparam int RM_LO    = 0;
  localparam int IMM8_HI  = 7;
  localparam int IMM5_HI  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } issue_state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return (op == OP_MOV) || (op == OP_ALU);
  endfunction

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic signed [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: DEPTH entries of DATA_W bits, no bypass path.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write request (ignored while full)
//   pop          read request (caller only asserts when count > 0)
//   wr_data      word to write
//   rd_data      head-of-queue word (valid while count > 0)
//   count        occupied entries
//   full         count == DEPTH
module instr_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is data only; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two DEPTH lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: buffers 16-bit instructions, decodes the head word into
// the instruction register and pulses start to the controller, holding all
// decoded fields until the controller returns to its wait state.
// Optional feature macro: INSTR_ISSUER_RETIRE_CNT_EN adds a 16-bit retired
// instruction counter output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_instr    instruction offer from the source
//   in_ready              FIFO has room
//   waiting               controller idle in its wait state
//   start                 one-cycle issue pulse
//   opcode..sximm5        decoded fields of the instruction register
//   busy                  an instruction is in flight
//   fifo_count            queued instructions
//   illegal               one-cycle pulse when a popped word was dropped
//   retired               (feature macro only) completed instruction count
module instr_issuer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [15:0]                in_instr,
  output logic                       in_ready,
  input  logic                       waiting,
  output logic                       start,
  output logic [2:0]                 opcode,
  output logic [1:0]                 ALU_op,
  output logic [1:0]                 shift_op,
  output logic [2:0]                 rn,
  output logic [2:0]                 rd,
  output logic [2:0]                 rm,
  output logic [15:0]                sximm8,
  output logic [15:0]                sximm5,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       illegal
`ifdef INSTR_ISSUER_RETIRE_CNT_EN
  ,
  output logic [15:0]                retired
`endif
);

  issue_state_t state, state_nx;
  logic [15:0]  ir;
  logic [15:0]  head;
  logic         full;
  logic         pop;
  logic         load;
  logic         ill_set;
  logic         retire;
  logic         busy_first;
  logic         head_legal;

  instr_fifo #(.DEPTH(DEPTH), .DATA_W(16)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .pop     (pop),
    .wr_data (in_instr),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full)
  );

  assign in_ready   = !full;
  assign head_legal = is_legal(head[OPC_HI:OPC_LO]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy_first <= 1'b0;
      illegal    <= 1'b0;
      ir         <= '0;
    end else begin
      state      <= state_nx;
      // The controller drops waiting during the first busy cycle, so that
      // cycle must not be mistaken for completion.
      busy_first <= (state == S_START);
      illegal    <= ill_set;
      if (load) ir <= head;
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    ill_set  = 1'b0;
    retire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (waiting && (fifo_count != '0)) begin
          pop = 1'b1;
          if (head_legal) begin
            load     = 1'b1;
            state_nx = S_START;
          end else begin
            ill_set = 1'b1;
          end
        end
      end
      S_START: state_nx = S_BUSY;
      S_BUSY: begin
        if (waiting && !busy_first) begin
          retire = 1'b1;
          if (fifo_count != '0) begin
            pop = 1'b1;
            if (head_legal) begin
              load     = 1'b1;
              state_nx = S_START;
            end else begin
              ill_set  = 1'b1;
              state_nx = S_IDLE;
            end
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    start    = (state == S_START);
    busy     = (state != S_IDLE);
    opcode   = ir[OPC_HI:OPC_LO];
    ALU_op   = ir[ALU_HI:ALU_LO];
    shift_op = ir[SH_HI:SH_LO];
    rn       = ir[RN_HI:RN_LO];
    rd       = ir[RD_HI:RD_LO];
    rm       = ir[RM_HI:RM_LO];
    sximm8   = sext8(ir[IMM8_HI:0]);
    sximm5   = sext5(ir[IMM5_HI:0]);
  end

`ifdef INSTR_ISSUER_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + 16'd1;
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
